cpu_6502: RTL and testbench
===========================

# cpu_6502

Reduced-instruction-set 6502-compatible CPU core with one memory access per clock on a 16-bit address bus and separate 8-bit data-in/data-out buses. It is the processor at the top of the system, driving a single external memory (RAM/ROM, up to 64 KiB) directly. The core fetches its start address from the reset vector and executes a documented 6502 opcode subset with 6502 cycle counts.

## Interface
- No parameters.
- clk_in  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- READ_write  output  1  1 = write cycle (memory latches data_out at next clk_in rise), 0 = read cycle.
- data_in  input  8  read data from memory; combinational function of address_out, sampled on clk_in rise.
- data_out  output  8  write data; valid whenever READ_write=1.
- address_out  output  16  bus address; registered, changes only on clk_in rise.

## Operation
- Registers: A, X, Y (8b); PC (16b); SP (8b, reset 8'hFD, unused by subset); P flags N, Z, C (others read 0). Reset: A=X=Y=0, N=Z=C=0.
- Reset vector: after reset deasserts, cycle 1 reads $FFFC (PCL), cycle 2 reads $FFFD (PCH), cycle 3 fetches the opcode at {PCH,PCL}.
- Subset (opcode, cycles):
  - LDA # A9/2, LDX # A2/2, LDY # A0/2.
  - LDA abs AD/4, STA abs 8D/4, STA zp 85/3.
  - ADC # 69/2, binary only (no decimal mode); C in/out.
  - INX E8/2, INY C8/2, DEX CA/2, TAX AA/2.
  - CLC 18/2, SEC 38/2, NOP EA/2.
  - JMP abs 4C/3.
  - BEQ F0, BNE D0: 2 cycles not taken, 3 cycles taken; no page-cross penalty; target = PC of next instruction + sign-extended offset, 16-bit wrap.
- Any other opcode: executes as 2-cycle NOP (1-byte).
- Flags: loads, INX/INY/DEX/TAX/ADC set N=bit7, Z=(result==0); ADC C = carry out of bit 7; STA/JMP/branches/NOP leave flags unchanged.
- Arithmetic modulo 256; INX of FF gives 00 with Z=1; DEX of 00 gives FF with N=1.
- PC increments modulo 2^16 (FFFF -> 0000).

## Timing
- While reset=0: address_out=16'hFFFC, READ_write=0, data_out=8'h00, state=VEC_LO; takes effect immediately (asynchronously), including mid-instruction or mid-write.
- FSM states: VEC_LO, VEC_HI, FETCH, OP1, OP2, EXEC/WRITE, BRANCH. FETCH reads opcode at PC, PC+1; OP1/OP2 read operand bytes; register results commit on the edge that ends the instruction's last cycle.
- Single-cycle memory latency: the byte on data_in during cycle n is consumed on the rising edge ending cycle n.
- Store: final cycle drives address_out=effective address, data_out=A, READ_write=1 for exactly one cycle; all other cycles READ_write=0.
- Operand-fetch cycles are counted in the cycle totals; no fetch overlap/pipelining is required.

## Structure
- Package cpu6502_pkg: opcode localparams, FSM state enum, flag bit indices, reset-vector address constant.
- One sub-module natural: cpu6502_alu (8-bit add-with-carry, increment/decrement, pass-through; outputs result, N, Z, C).
- Top holds registers, FSM and bus muxing.

## Test plan
- Reset vector: mem[$FFFC]=00, mem[$FFFD]=80; release reset -> address_out $FFFC, $FFFD, then $8000 on the third cycle.
- Load/store: $8000: A9 42 8D 00 02 -> mem[$0200]=42 written on cycle 6 after vector fetch, READ_write high exactly one cycle.
- ADC carry: LDA #$F0; SEC; ADC #$0F -> A=00, Z=1, C=1; STA zp $10 writes 00.
- Loop: LDX #$03; DEX; BNE -3 -> X counts 2,1,0; branch taken twice (3 cycles each), falls through when Z=1.
- JMP: 4C 00 90 -> next opcode fetch at $9000 exactly 3 cycles after fetching 4C.
- Reset mid-store: assert reset during STA write cycle -> READ_write drops to 0 immediately, address_out=$FFFC; restart refetches vector.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared definitions for the cpu_6502 core: opcodes, FSM states, ALU ops,
// status-flag bit positions and the reset vector.
package cpu6502_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_BNE     = 8'hD0;

    localparam logic [2:0] FLAG_C = 3'd0;
    localparam logic [2:0] FLAG_Z = 3'd1;
    localparam logic [2:0] FLAG_V = 3'd6;
    localparam logic [2:0] FLAG_N = 3'd7;

    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, OP1, OP2, EXEC, WRITE, BRANCH
    } CpuState;

    typedef enum logic [1:0] {
        ALU_PASS, ALU_ADC, ALU_INC, ALU_DEC
    } AluOp;

    function automatic logic hasOperand(input logic [7:0] opcode);
        case (opcode)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_LDA_ABS, OP_STA_ABS,
            OP_STA_ZP, OP_ADC_IMM, OP_JMP_ABS, OP_BEQ, OP_BNE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 6502 branch opcodes pick their flag with bits 7:6 (N, V, C, Z order)
    function automatic logic [2:0] branchFlagIndex(input logic [1:0] sel);
        case (sel)
            2'd0:    return FLAG_N;
            2'd1:    return FLAG_V;
            2'd2:    return FLAG_C;
            default: return FLAG_Z;
        endcase
    endfunction

endpackage

// File: rtl/cpu6502_alu.sv
// 8-bit ALU for the cpu_6502 core: binary add-with-carry, increment,
// decrement and pass-through of operand B, with N/Z/C outputs.
module cpu6502_alu
    import cpu6502_pkg::*;
(
    input  AluOp       i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_carry,
    output logic [7:0] o_result,
    output logic       o_n,
    output logic       o_z,
    output logic       o_c
);

    logic [8:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_carry};

    always_comb begin
        o_result = i_b;
        o_c      = i_carry;
        case (i_op)
            ALU_ADC: begin
                o_result = w_sum[7:0];
                o_c      = w_sum[8];
            end
            ALU_INC: o_result = i_a + 8'd1;
            ALU_DEC: o_result = i_a - 8'd1;
            default: ;
        endcase
    end

    assign o_n = o_result[7];
    assign o_z = (o_result == 8'h00);

endmodule

// File: rtl/cpu_6502.sv
// Reduced 6502-compatible core: one registered bus access per clock, reset
// vector fetch, and a small opcode subset with 6502 cycle counts.
module cpu_6502
    import cpu6502_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset,
    output logic        READ_write,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [15:0] address_out
);

    CpuState     r_state;
    logic [15:0] r_pc;
    logic [15:0] r_address;
    logic [7:0]  r_opcode;
    logic [7:0]  r_operandLo;
    logic [7:0]  r_regA;
    logic [7:0]  r_regX;
    logic [7:0]  r_regY;
    logic [7:0]  r_dataOut;
    logic        r_write;
    logic        r_flagN;
    logic        r_flagZ;
    logic        r_flagC;

    AluOp        w_aluOp;
    logic [7:0]  w_aluA;
    logic [7:0]  w_aluB;
    logic [7:0]  w_aluResult;
    logic        w_aluN;
    logic        w_aluZ;
    logic        w_aluC;
    logic [7:0]  w_status;
    logic [15:0] w_pcNext;
    logic [15:0] w_branchTarget;
    logic        w_branchTaken;

    assign address_out = r_address;
    assign READ_write  = r_write;
    assign data_out    = r_dataOut;

    assign w_pcNext       = r_pc + 16'd1;
    assign w_branchTarget = w_pcNext + {{8{data_in[7]}}, data_in};

    always_comb begin
        w_status         = 8'h00;
        w_status[FLAG_N] = r_flagN;
        w_status[FLAG_Z] = r_flagZ;
        w_status[FLAG_C] = r_flagC;
    end

    assign w_branchTaken = (w_status[branchFlagIndex(r_opcode[7:6])] == r_opcode[5]);

    // Operand B defaults to the bus so immediates and absolute loads pass straight through
    always_comb begin
        w_aluOp = ALU_PASS;
        w_aluA  = r_regA;
        w_aluB  = data_in;
        if (r_state == EXEC) begin
            case (r_opcode)
                OP_INX: begin w_aluOp = ALU_INC; w_aluA = r_regX; end
                OP_INY: begin w_aluOp = ALU_INC; w_aluA = r_regY; end
                OP_DEX: begin w_aluOp = ALU_DEC; w_aluA = r_regX; end
                OP_TAX: w_aluB = r_regA;
                default: ;
            endcase
        end else if (r_opcode == OP_ADC_IMM) begin
            w_aluOp = ALU_ADC;
        end
    end

    cpu6502_alu u_alu (
        .i_op     (w_aluOp),
        .i_a      (w_aluA),
        .i_b      (w_aluB),
        .i_carry  (r_flagC),
        .o_result (w_aluResult),
        .o_n      (w_aluN),
        .o_z      (w_aluZ),
        .o_c      (w_aluC)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= VEC_LO;
            r_pc        <= 16'h0000;
            r_address   <= RESET_VECTOR;
            r_write     <= 1'b0;
            r_dataOut   <= 8'h00;
            r_opcode    <= OP_NOP;
            r_operandLo <= 8'h00;
            r_regA      <= 8'h00;
            r_regX      <= 8'h00;
            r_regY      <= 8'h00;
            r_flagN     <= 1'b0;
            r_flagZ     <= 1'b0;
            r_flagC     <= 1'b0;
        end else begin
            r_write   <= 1'b0;
            r_dataOut <= 8'h00;
            case (r_state)
                VEC_LO: begin
                    r_pc[7:0] <= data_in;
                    r_address <= RESET_VECTOR + 16'd1;
                    r_state   <= VEC_HI;
                end
                VEC_HI: begin
                    r_pc      <= {data_in, r_pc[7:0]};
                    r_address <= {data_in, r_pc[7:0]};
                    r_state   <= FETCH;
                end
                FETCH: begin
                    r_opcode  <= data_in;
                    r_pc      <= w_pcNext;
                    r_address <= w_pcNext;
                    r_state   <= hasOperand(data_in) ? OP1 : EXEC;
                end
                OP1: begin
                    r_operandLo <= data_in;
                    r_pc        <= w_pcNext;
                    r_address   <= w_pcNext;
                    r_state     <= FETCH;
                    case (r_opcode)
                        OP_LDA_IMM, OP_ADC_IMM: begin
                            r_regA  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                            if (r_opcode == OP_ADC_IMM) r_flagC <= w_aluC;
                        end
                        OP_LDX_IMM: begin
                            r_regX  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                        end
                        OP_LDY_IMM: begin
                            r_regY  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                        end
                        OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: r_state <= OP2;
                        OP_STA_ZP: begin
                            r_address <= {8'h00, data_in};
                            r_write   <= 1'b1;
                            r_dataOut <= r_regA;
                            r_state   <= WRITE;
                        end
                        OP_BEQ, OP_BNE: begin
                            if (w_branchTaken) begin
                                r_pc    <= w_branchTarget;
                                r_state <= BRANCH;
                            end
                        end
                        default: ;
                    endcase
                end
                OP2: begin
                    r_pc      <= w_pcNext;
                    r_address <= {data_in, r_operandLo};
                    r_state   <= EXEC;
                    if (r_opcode == OP_JMP_ABS) begin
                        r_pc    <= {data_in, r_operandLo};
                        r_state <= FETCH;
                    end else if (r_opcode == OP_STA_ABS) begin
                        r_write   <= 1'b1;
                        r_dataOut <= r_regA;
                        r_state   <= WRITE;
                    end
                end
                EXEC: begin
                    r_address <= r_pc;
                    r_state   <= FETCH;
                    case (r_opcode)
                        OP_LDA_ABS: begin
                            r_regA  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                        end
                        OP_INX, OP_DEX, OP_TAX: begin
                            r_regX  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                        end
                        OP_INY: begin
                            r_regY  <= w_aluResult;
                            r_flagN <= w_aluN;
                            r_flagZ <= w_aluZ;
                        end
                        OP_CLC: r_flagC <= 1'b0;
                        OP_SEC: r_flagC <= 1'b1;
                        default: ;
                    endcase
                end
                WRITE, BRANCH: begin
                    r_address <= r_pc;
                    r_state   <= FETCH;
                end
                default: r_state <= VEC_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_6502.sv
// Self-checking bench for cpu_6502: a hand-computed bus trace of a test
// program plus directed reset sequences, against a simple memory model.
module tb_cpu_6502;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
    } BusVec;

    logic        clk_in;
    logic        reset;
    logic        READ_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] address_out;

    logic [7:0]  romMem   [0:65535];
    logic [7:0]  ramMem   [0:65535];
    bit          ramValid [0:65535];
    int          writeCount = 0;
    int          writesBefore;
    int          checkCount = 0;
    int          errorCount = 0;
    BusVec       busTrace [$];

    logic [7:0] code8000 [30] = '{
        8'hA9, 8'h42, 8'h8D, 8'h00, 8'h02, 8'hA9, 8'hF0, 8'h38,
        8'h69, 8'h0F, 8'h85, 8'h10, 8'hF0, 8'h02, 8'hEA, 8'hEA,
        8'hA2, 8'h03, 8'hCA, 8'hD0, 8'hFD, 8'h18, 8'h69, 8'h01,
        8'h8D, 8'h34, 8'h12, 8'h4C, 8'h00, 8'h90};

    logic [7:0] code9000 [35] = '{
        8'hAD, 8'h00, 8'h02, 8'hC8, 8'h02, 8'h69, 8'hBE, 8'hD0,
        8'h05, 8'h85, 8'h20, 8'h69, 8'h00, 8'h85, 8'h21, 8'hA2,
        8'hFF, 8'hE8, 8'hF0, 8'h01, 8'hEA, 8'hCA, 8'hF0, 8'h05,
        8'hA0, 8'h00, 8'hF0, 8'h00, 8'hAA, 8'hD0, 8'h01, 8'hEA,
        8'h4C, 8'hFE, 8'hFF};

    cpu_6502 dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .READ_write  (READ_write),
        .data_in     (data_in),
        .data_out    (data_out),
        .address_out (address_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Stores overlay the program image so later loads see what was written
    always @(posedge clk_in) begin
        if (READ_write) begin
            ramMem[address_out]   <= data_out;
            ramValid[address_out] <= 1'b1;
            writeCount            <= writeCount + 1;
        end
    end

    assign data_in = ramValid[address_out] ? ramMem[address_out] : romMem[address_out];

    task automatic applyStimulus(input logic rstLevel, input int cycles);
        reset = rstLevel;
        repeat (cycles) @(negedge clk_in);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addReads(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) busTrace.push_back('{start + 16'(i), 1'b0, 8'h00});
    endtask

    task automatic addWrite(input logic [15:0] addr, input logic [7:0] data);
        busTrace.push_back('{addr, 1'b1, data});
    endtask

    task automatic checkBus(input string name, input logic [15:0] addr,
                            input logic rw, input logic [7:0] data);
        checkOutput(name,
                    {7'd0, address_out, READ_write, READ_write ? data_out : 8'h00},
                    {7'd0, addr, rw, data});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int a = 0; a < 65536; a++) romMem[16'(a)] = 8'hEA;
        romMem[16'hFFFC] = 8'h00;
        romMem[16'hFFFD] = 8'h80;
        for (int i = 0; i < 30; i++) romMem[16'h8000 + 16'(i)] = code8000[i];
        for (int i = 0; i < 35; i++) romMem[16'h9000 + 16'(i)] = code9000[i];

        // Vector, LDA#, STA abs, LDA#, SEC, ADC#, STA zp, BEQ taken
        addReads(16'hFFFC, 2); addReads(16'h8000, 2); addReads(16'h8002, 3);
        addWrite(16'h0200, 8'h42); addReads(16'h8005, 2); addReads(16'h8007, 2);
        addReads(16'h8008, 2); addReads(16'h800A, 2); addWrite(16'h0010, 8'h00);
        addReads(16'h800C, 3);
        // LDX #3; DEX; BNE loop: taken twice, then falls through
        addReads(16'h8010, 2);
        for (int k = 0; k < 2; k++) begin
            addReads(16'h8012, 2); addReads(16'h8013, 3);
        end
        addReads(16'h8012, 2); addReads(16'h8013, 2);
        // CLC; ADC #1; STA abs; JMP $9000
        addReads(16'h8015, 2); addReads(16'h8016, 2); addReads(16'h8018, 3);
        addWrite(16'h1234, 8'h01); addReads(16'h801B, 3);
        // LDA abs, INY, unknown op, ADC carry out, BNE, STA zp, ADC carry in, STA zp
        addReads(16'h9000, 3); addReads(16'h0200, 1); addReads(16'h9003, 2);
        addReads(16'h9004, 2); addReads(16'h9005, 2); addReads(16'h9007, 2);
        addReads(16'h9009, 2); addWrite(16'h0020, 8'h00); addReads(16'h900B, 2);
        addReads(16'h900D, 2); addWrite(16'h0021, 8'h01);
        // INX wrap, BEQ taken, DEX wrap, BEQ not taken, LDY, BEQ +0, TAX, BNE taken
        addReads(16'h900F, 2); addReads(16'h9011, 2); addReads(16'h9012, 3);
        addReads(16'h9015, 2); addReads(16'h9016, 2); addReads(16'h9018, 2);
        addReads(16'h901A, 3); addReads(16'h901C, 2); addReads(16'h901D, 3);
        // JMP $FFFE; NOPs wrap the PC through $FFFF to $0000
        addReads(16'h9020, 3); addReads(16'hFFFE, 2); addReads(16'hFFFF, 2);
        addReads(16'h0000, 1);

        applyStimulus(1'b0, 3);
        checkOutput("reset address_out", {16'd0, address_out}, 32'h0000FFFC);
        checkOutput("reset READ_write", {31'd0, READ_write}, 32'd0);
        checkOutput("reset data_out", {24'd0, data_out}, 32'd0);

        applyStimulus(1'b1, 0);
        for (int i = 0; i < busTrace.size(); i++) begin
            if (i > 0) @(negedge clk_in);
            checkBus($sformatf("bus cycle %0d", i + 1),
                     busTrace[i].addr, busTrace[i].rw, busTrace[i].data);
        end
        checkOutput("store count", writeCount, 32'd5);

        // Reset asserted in the middle of an STA abs write cycle
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 7);
        checkBus("store cycle before reset", 16'h0200, 1'b1, 8'h42);
        writesBefore = writeCount;
        #2 reset = 1'b0;
        #1;
        checkOutput("abort READ_write", {31'd0, READ_write}, 32'd0);
        checkOutput("abort address_out", {16'd0, address_out}, 32'h0000FFFC);
        checkOutput("abort data_out", {24'd0, data_out}, 32'd0);
        applyStimulus(1'b0, 1);
        checkOutput("aborted store not written", writeCount, writesBefore);
        applyStimulus(1'b1, 0);
        checkBus("restart cycle 1", 16'hFFFC, 1'b0, 8'h00);
        applyStimulus(1'b1, 1);
        checkBus("restart cycle 2", 16'hFFFD, 1'b0, 8'h00);
        applyStimulus(1'b1, 1);
        checkBus("restart cycle 3", 16'h8000, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
